// File: rtl/boa_fence_pkg.sv
// ============================================================================
// Module  : boa_fence_pkg
// Brief   : Shared types and request decode for the fence controller.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package boa_fence_pkg;

  localparam int unsigned TIMER_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_ISSUE = 3'd1,
    D_ACK   = 3'd2,
    D_WAIT  = 3'd3,
    I_ISSUE = 3'd4,
    I_ACK   = 3'd5,
    I_WAIT  = 3'd6,
    DONE    = 3'd7
  } fence_state_t;

  typedef struct packed {
    logic dr;
    logic dw;
    logic ir;
  } fence_need_t;

  // Every fence flavour needs dirty data written back first.
  function automatic fence_need_t fence_decode(input logic rl, input logic aq, input logic i);
    fence_need_t n;
    n.dr = aq;
    n.dw = rl | aq | i;
    n.ir = i;
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/boa_fence_phase.sv
// ============================================================================
// Module  : boa_fence_phase
// Brief   : Acknowledge/timeout/drain tracking for one cache flush handshake.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module boa_fence_phase
  import boa_fence_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue_i,
  input  logic ack_i,
  input  logic flushing_i,
  output logic acked_o,
  output logic timeout_o,
  output logic quiet_o
);

  localparam logic [TIMER_W-1:0] c_limit = TIMER_W'(ACK_TIMEOUT - 1);

  logic [TIMER_W-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (issue_i) begin
      timer_d = '0;
    end else if (ack_i && (timer_q != '1)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // A live flushing level wins over an expiring timer.
  assign acked_o   = ack_i & flushing_i;
  assign timeout_o = ack_i & ~flushing_i & (timer_q >= c_limit);
  assign quiet_o   = ~flushing_i;

endmodule

`default_nettype wire

// File: rtl/boa_fence_ctl.sv
// ============================================================================
// Module  : boa_fence_ctl
// Brief   : Sequences D$ writeback/invalidate then I$ invalidate for fences.
//           Optional statistics counters under BOA_FENCE_STATS_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module boa_fence_ctl
  import boa_fence_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 4
`ifdef BOA_FENCE_STATS_EN
  ,
  parameter int unsigned CNT_WIDTH = 32
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic fence_rl,
  input  logic fence_aq,
  input  logic fence_i,
  output logic dcache_flush_r,
  output logic dcache_flush_w,
  output logic icache_flush_r,
  input  logic dcache_flushing_r,
  input  logic dcache_flushing_w,
  input  logic icache_flushing_r,
  output logic icache_stall,
  output logic fence_busy,
  output logic fence_done
`ifdef BOA_FENCE_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] fence_count,
  output logic [CNT_WIDTH-1:0] fence_cycles
`endif
);

  fence_state_t state_q, state_d, w_after_d;
  fence_need_t  active_q, active_d, pending_q, pending_d, w_req, w_need;
  logic         w_d_acked, w_d_timeout, w_d_quiet;
  logic         w_i_acked, w_i_timeout, w_i_quiet;

  assign w_req     = fence_decode(fence_rl, fence_aq, fence_i);
  assign w_need    = fence_need_t'(pending_q | w_req);
  assign w_after_d = active_q.ir ? I_ISSUE : DONE;

  boa_fence_phase #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_dphase (
    .clk        (clk),
    .rst        (rst),
    .issue_i    (state_q == D_ISSUE),
    .ack_i      (state_q == D_ACK),
    .flushing_i (dcache_flushing_r | dcache_flushing_w),
    .acked_o    (w_d_acked),
    .timeout_o  (w_d_timeout),
    .quiet_o    (w_d_quiet)
  );

  boa_fence_phase #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_iphase (
    .clk        (clk),
    .rst        (rst),
    .issue_i    (state_q == I_ISSUE),
    .ack_i      (state_q == I_ACK),
    .flushing_i (icache_flushing_r),
    .acked_o    (w_i_acked),
    .timeout_o  (w_i_timeout),
    .quiet_o    (w_i_quiet)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      active_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  // Requests outside IDLE only accumulate; the active vector is frozen.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pending_d = w_need;
    case (state_q)
      IDLE: begin
        if (w_need != '0) begin
          active_d  = w_need;
          pending_d = '0;
          state_d   = (w_need.dr | w_need.dw) ? D_ISSUE : I_ISSUE;
        end
      end
      D_ISSUE: state_d = D_ACK;
      D_ACK: begin
        if (w_d_acked)        state_d = D_WAIT;
        else if (w_d_timeout) state_d = w_after_d;
      end
      D_WAIT:  if (w_d_quiet) state_d = w_after_d;
      I_ISSUE: state_d = I_ACK;
      I_ACK: begin
        if (w_i_acked)        state_d = I_WAIT;
        else if (w_i_timeout) state_d = DONE;
      end
      I_WAIT:  if (w_i_quiet) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dcache_flush_r = 1'b0;
    dcache_flush_w = 1'b0;
    icache_flush_r = 1'b0;
    fence_done     = 1'b0;
    case (state_q)
      D_ISSUE: begin
        dcache_flush_r = active_q.dr;
        dcache_flush_w = active_q.dw;
      end
      I_ISSUE: icache_flush_r = 1'b1;
      DONE:    fence_done     = 1'b1;
      default: ;
    endcase
  end

  assign fence_busy   = (state_q != IDLE) || (pending_q != '0) || fence_rl || fence_aq || fence_i;
  assign icache_stall = dcache_flushing_w;

`ifdef BOA_FENCE_STATS_EN
  logic [CNT_WIDTH-1:0] count_q, count_d, cycles_q, cycles_d;

  always_comb begin
    count_d  = count_q;
    cycles_d = cycles_q;
    if (fence_done && (count_q != '1))  count_d  = count_q + 1'b1;
    if (fence_busy && (cycles_q != '1)) cycles_d = cycles_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      cycles_q <= '0;
    end else begin
      count_q  <= count_d;
      cycles_q <= cycles_d;
    end
  end

  assign fence_count  = count_q;
  assign fence_cycles = cycles_q;
`endif

endmodule

`default_nettype wire

// File: doc/boa_fence_ctl.md
Name: boa_fence_ctl

Overview:
- Sequences cache maintenance for CPU fence instructions. Sits between the CPU fence outputs (fence_rl, fence_aq, fence_i) and the flush/flushing handshakes of the data and instruction caches.
- Orders the work so dirty data-cache lines are written back before the instruction cache is invalidated.
- Stalls the CPU until the whole fence sequence has completed.

Parameters:
- ack_timeout, 4: cycles to wait for a cache's flushing signal to rise after a flush pulse before treating that cache as already clean (1..255).
- cnt_width, 32: width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  CPU clock.
- rst  in  1  synchronous reset, active-high.
- fence_rl  in  1  release fence request, single-cycle pulse.
- fence_aq  in  1  acquire fence request, single-cycle pulse.
- fence_i  in  1  instruction fence request, single-cycle pulse.
- dcache_flush_r  out  1  data-cache invalidate pulse.
- dcache_flush_w  out  1  data-cache writeback pulse.
- icache_flush_r  out  1  instruction-cache invalidate pulse.
- dcache_flushing_r  in  1  data-cache invalidate in progress.
- dcache_flushing_w  in  1  data-cache writeback in progress.
- icache_flushing_r  in  1  instruction-cache invalidate in progress.
- icache_stall  out  1  holds instruction-cache refills while a data-cache writeback is in progress.
- fence_busy  out  1  CPU stall; high while any fence is pending or active.
- fence_done  out  1  single-cycle pulse when a sequence completes.

Behaviour:
- Reset: all outputs 0; state IDLE; pending bits cleared; timer 0. Reset mid-sequence abandons the sequence immediately with no further flush pulses; the caches' own reset clears their state.
- Request decode into a 3-bit need vector {dr, dw, ir}:
  - fence_rl sets dw.
  - fence_aq sets dr and dw.
  - fence_i sets dw and ir.
  - Simultaneous requests OR together.
- Pending latch: requests are OR-ed into a pending vector every cycle. In IDLE with a nonzero need (pending OR this cycle's inputs), the controller loads the active vector, clears pending and goes to D_ISSUE in the next cycle.
- fence_busy is combinational: (state != IDLE) || pending != 0 || any fence input high. The CPU therefore stalls in the same cycle as the request.
- States:
  - IDLE.
  - D_ISSUE: entered only if dr|dw, otherwise skipped to I_ISSUE. Drives dcache_flush_r=dr and dcache_flush_w=dw for exactly one cycle. Timer := 0.
  - D_ACK: waits for dcache_flushing_r|dcache_flushing_w. If seen, go to D_WAIT. If the timer reaches ack_timeout with no flushing seen, go to the next phase.
  - D_WAIT: stays until dcache_flushing_r and dcache_flushing_w are both 0.
  - I_ISSUE: entered only if ir. icache_flush_r=1 for one cycle.
  - I_ACK and I_WAIT: same handshake as the data-cache phase, on icache_flushing_r.
  - DONE: fence_done=1 for one cycle, then IDLE. A nonzero pending vector restarts in the cycle after DONE.
- Latency, fence_rl with the data cache clean and timeout 4: request at cycle 0, D_ISSUE at 1, D_ACK at 2..5, DONE at 6, fence_busy low at 7.
- Requests arriving while not in IDLE only set pending; they never alter the active vector. Repeated identical requests merge.
- icache_stall = dcache_flushing_w, registered-free.
- A flushing signal already high when D_ISSUE is entered counts as acknowledge in D_ACK.
- The timer saturates; it never wraps.

Optional Feature:
- Macro BOA_FENCE_STATS_EN.
- With it defined, two extra output ports are added, each cnt_width wide and reset to 0:
  - fence_count: increments on each fence_done pulse.
  - fence_cycles: increments on each cycle fence_busy=1.
  - Both counters saturate at all-ones.
- Without it, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package boa_fence_pkg holds:
  - the state enum fence_state_t (IDLE, D_ISSUE, D_ACK, D_WAIT, I_ISSUE, I_ACK, I_WAIT, DONE);
  - typedef fence_need_t (packed struct dr, dw, ir);
  - the function fence_decode(rl, aq, i) returning fence_need_t.
- One sub-module, boa_fence_phase, handles the issue/ack/wait handshake for a single cache with a timeout. It is instantiated twice (data cache, instruction cache); the top-level FSM chains the two phases.

Test Plan:
- fence_rl pulse, caches never assert flushing, ack_timeout=4 -> dcache_flush_w one pulse at cycle 1, no flush_r or icache pulse, fence_done at cycle 6, fence_busy high for cycles 0..6.
- fence_i pulse; model raises dcache_flushing_w at cycle 2 for 10 cycles -> icache_stall high in exactly those cycles, icache_flush_r pulses only after dcache_flushing_w falls, then fence_done.
- fence_aq and fence_i in the same cycle -> a single sequence with dr=dw=ir=1; exactly one pulse of each flush output.
- fence_aq pulse while in D_WAIT -> current sequence completes, fence_done pulses, the new sequence's D_ISSUE follows 2 cycles later, fence_busy never drops between them.
- rst asserted during I_WAIT -> next cycle all outputs 0, state IDLE, no flush pulses after reset.
- BOA_FENCE_STATS_EN defined, three back-to-back fence_rl sequences of 7 busy cycles each, 8-bit counters -> fence_count=3, fence_cycles=21. Forced near-overflow -> both counters saturate at 255.
